// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and the
// byte-lane merge helper used by register-file style slaves.
package axi4l_pkg;

    localparam int AXI4L_MAX_DATA_WIDTH = 64;
    localparam int AXI4L_MAX_STRB_WIDTH = AXI4L_MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4l_resp_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Byte-lane merge at the widest supported bus width; narrower callers
    // zero-extend their operands and truncate the result.
    function automatic logic [AXI4L_MAX_DATA_WIDTH-1:0] strb_merge(
        input logic [AXI4L_MAX_DATA_WIDTH-1:0] old_data,
        input logic [AXI4L_MAX_DATA_WIDTH-1:0] new_data,
        input logic [AXI4L_MAX_STRB_WIDTH-1:0] strb
    );
        logic [AXI4L_MAX_DATA_WIDTH-1:0] merged;
        for (int k = 0; k < AXI4L_MAX_STRB_WIDTH; k++) begin
            merged[k*8 +: 8] = strb[k] ? new_data[k*8 +: 8] : old_data[k*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4l_regfile.sv
// AXI4-Lite slave register file: NUM_REGS registers with byte strobes,
// per-register read-only mapping onto reg_d, and SLVERR/DECERR responses.
// Read and write channels are fully independent; one outstanding write.
module axi4l_regfile
    import axi4l_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 12,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output axi4l_resp_t                    s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output axi4l_resp_t                    s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_WIDTH:0] NUM_REGS_W = (IDX_WIDTH+1)'(NUM_REGS);

    if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_data_width
        $error("axi4l_regfile: DATA_WIDTH must be 32 or 64");
    end
    if ((NUM_REGS < 1) || (NUM_REGS > (2 ** IDX_WIDTH))) begin : g_bad_num_regs
        $error("axi4l_regfile: NUM_REGS out of range for ADDR_WIDTH");
    end

    // Register storage (RO entries are never enabled and stay zero)
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    // Write channel state
    wr_state_t             wr_state_r, wr_state_s;
    logic                  aw_held_r, aw_held_s;
    logic                  w_held_r, w_held_s;
    logic [IDX_WIDTH-1:0]  wr_idx_r, wr_idx_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic [STRB_WIDTH-1:0] wstrb_r, wstrb_s;
    logic                  awready_r, awready_s;
    logic                  wready_r, wready_s;
    logic                  bvalid_r, bvalid_s;
    axi4l_resp_t           bresp_r, bresp_s;
    logic [NUM_REGS-1:0]   wr_en_s;
    logic [NUM_REGS-1:0]   reg_wr_r;

    // Write decode
    logic [NUM_REGS-1:0]   wr_hit_s;
    logic                  wr_in_range_s;
    logic                  wr_ro_s;
    axi4l_resp_t           wr_resp_s;
    logic [DATA_WIDTH-1:0] wr_old_s;
    logic [DATA_WIDTH-1:0] wr_merged_s;

    // Read channel state
    rd_state_t             rd_state_r, rd_state_s;
    logic                  arready_r, arready_s;
    logic                  rvalid_r, rvalid_s;
    axi4l_resp_t           rresp_r, rresp_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_s;

    // Read decode
    logic [IDX_WIDTH-1:0]  rd_idx_s;
    logic                  rd_in_range_s;
    logic [DATA_WIDTH-1:0] rd_sel_s;

    // Address offset bits below the register granule carry no meaning
    logic                  unused_ok_s;
    assign unused_ok_s = ^{s_awaddr[ADDR_LSB-1:0], s_araddr[ADDR_LSB-1:0]};

    // Decode the held write address and build the merged write value
    always_comb begin
        wr_in_range_s = ({1'b0, wr_idx_r} < NUM_REGS_W);
        wr_old_s      = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit_s[i] = (wr_idx_r == IDX_WIDTH'(i));
            wr_old_s    = wr_old_s | ({DATA_WIDTH{wr_hit_s[i]}} & regs_r[i]);
        end
        wr_ro_s = |(wr_hit_s & RO_MASK);
        if (!wr_in_range_s) begin
            wr_resp_s = DECERR;
        end else if (wr_ro_s) begin
            wr_resp_s = SLVERR;
        end else begin
            wr_resp_s = OKAY;
        end
        wr_merged_s = DATA_WIDTH'(strb_merge(AXI4L_MAX_DATA_WIDTH'(wr_old_s),
                                             AXI4L_MAX_DATA_WIDTH'(wdata_r),
                                             AXI4L_MAX_STRB_WIDTH'(wstrb_r)));
    end

    // Write FSM next state: capture AW and W independently, commit when both are held
    always_comb begin
        wr_state_s = wr_state_r;
        aw_held_s  = aw_held_r;
        w_held_s   = w_held_r;
        wr_idx_s   = wr_idx_r;
        wdata_s    = wdata_r;
        wstrb_s    = wstrb_r;
        awready_s  = awready_r;
        wready_s   = wready_r;
        bvalid_s   = bvalid_r;
        bresp_s    = bresp_r;
        wr_en_s    = {NUM_REGS{1'b0}};
        case (wr_state_r)
            WR_IDLE: begin
                if (aw_held_r && w_held_r) begin
                    wr_state_s = WR_RESP;
                    bvalid_s   = 1'b1;
                    bresp_s    = wr_resp_s;
                    awready_s  = 1'b0;
                    wready_s   = 1'b0;
                    if (wr_resp_s == OKAY) begin
                        wr_en_s = wr_hit_s;
                    end else begin
                        wr_en_s = {NUM_REGS{1'b0}};
                    end
                end else begin
                    if (s_awvalid && awready_r) begin
                        aw_held_s = 1'b1;
                        wr_idx_s  = s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
                        awready_s = 1'b0;
                    end else begin
                        awready_s = !aw_held_r;
                    end
                    if (s_wvalid && wready_r) begin
                        w_held_s = 1'b1;
                        wdata_s  = s_wdata;
                        wstrb_s  = s_wstrb;
                        wready_s = 1'b0;
                    end else begin
                        wready_s = !w_held_r;
                    end
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    wr_state_s = WR_IDLE;
                    bvalid_s   = 1'b0;
                    aw_held_s  = 1'b0;
                    w_held_s   = 1'b0;
                    awready_s  = 1'b1;
                    wready_s   = 1'b1;
                end else begin
                    bvalid_s = 1'b1;
                end
            end
            default: begin
                wr_state_s = WR_IDLE;
                aw_held_s  = 1'b0;
                w_held_s   = 1'b0;
                awready_s  = 1'b0;
                wready_s   = 1'b0;
                bvalid_s   = 1'b0;
            end
        endcase
    end

    // Write FSM state and write-channel output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_r <= WR_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            wr_idx_r   <= {IDX_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wstrb_r    <= {STRB_WIDTH{1'b0}};
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= OKAY;
            reg_wr_r   <= {NUM_REGS{1'b0}};
        end else begin
            wr_state_r <= wr_state_s;
            aw_held_r  <= aw_held_s;
            w_held_r   <= w_held_s;
            wr_idx_r   <= wr_idx_s;
            wdata_r    <= wdata_s;
            wstrb_r    <= wstrb_s;
            awready_r  <= awready_s;
            wready_r   <= wready_s;
            bvalid_r   <= bvalid_s;
            bresp_r    <= bresp_s;
            reg_wr_r   <= wr_en_s;
        end
    end

    // Register array update on an accepted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s[i]) begin
                    regs_r[i] <= wr_merged_s;
                end
            end
        end
    end

    // Read decode: RO registers map to reg_d, out-of-range reads return zero
    always_comb begin
        rd_idx_s      = s_araddr[ADDR_WIDTH-1:ADDR_LSB];
        rd_in_range_s = ({1'b0, rd_idx_s} < NUM_REGS_W);
        rd_sel_s      = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_sel_s = rd_sel_s
                     | ({DATA_WIDTH{rd_idx_s == IDX_WIDTH'(i)}}
                        & (RO_MASK[i] ? reg_d[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i]));
        end
    end

    // Read FSM next state: register data/response on AR handshake, hold until rready
    always_comb begin
        rd_state_s = rd_state_r;
        arready_s  = arready_r;
        rvalid_s   = rvalid_r;
        rresp_s    = rresp_r;
        rdata_s    = rdata_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (s_arvalid && arready_r) begin
                    rd_state_s = RD_DATA;
                    arready_s  = 1'b0;
                    rvalid_s   = 1'b1;
                    rdata_s    = rd_sel_s;
                    if (rd_in_range_s) begin
                        rresp_s = OKAY;
                    end else begin
                        rresp_s = DECERR;
                    end
                end else begin
                    arready_s = 1'b1;
                end
            end
            RD_DATA: begin
                if (s_rready) begin
                    rd_state_s = RD_IDLE;
                    rvalid_s   = 1'b0;
                    arready_s  = 1'b1;
                end else begin
                    rvalid_s = 1'b1;
                end
            end
            default: begin
                rd_state_s = RD_IDLE;
                arready_s  = 1'b0;
                rvalid_s   = 1'b0;
            end
        endcase
    end

    // Read FSM state and read-channel output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rresp_r    <= OKAY;
            rdata_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_state_r <= rd_state_s;
            arready_r  <= arready_s;
            rvalid_r   <= rvalid_s;
            rresp_r    <= rresp_s;
            rdata_r    <= rdata_s;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? {DATA_WIDTH{1'b0}} : regs_r[g];
    end

    assign s_awready = awready_r;
    assign s_wready  = wready_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_arready = arready_r;
    assign s_rvalid  = rvalid_r;
    assign s_rresp   = rresp_r;
    assign s_rdata   = rdata_r;
    assign reg_wr    = reg_wr_r;

endmodule
